// File: rtl/join_none_slave.sv
// rtl/join_none_slave.sv - AHB-Lite slave in front of a word-organised on-chip SRAM
//
// Purpose: single AHB-Lite slave with zero wait states. Reads load the whole
// addressed word into HRDATA at the address-phase edge. Writes are captured
// at the address-phase edge and committed to the byte lanes in the data phase.
// HSIZE > 2 gets a two-cycle ERROR response with no memory access.
//
// Ports:
//   HCLK    in   1           bus clock, rising edge
//   HRESET  in   1           asynchronous active-high reset
//   HSEL    in   1           slave select
//   HADDR   in   ADDR_WIDTH  byte address
//   HTRANS  in   2           IDLE/BUSY/NONSEQ/SEQ
//   HWRITE  in   1           1 = write
//   HSIZE   in   3           0 byte, 1 half, 2 word, >2 error
//   HBURST  in   3           ignored
//   HPROT   in   4           ignored
//   HWDATA  in   DATA_WIDTH  write data (data phase)
//   HRDATA  out  DATA_WIDTH  registered read data
//   HREADY  out  1           HREADYOUT
//   HRESP   out  1           0 OKAY, 1 ERROR
module join_none_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write captured in its address phase, committed at the next edge
  logic                  wr_pend;
  logic [IDX_W-1:0]      wr_idx;
  logic [3:0]            wr_mask;

  logic                  valid;
  logic                  bad_size;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] rd_word;

  // Upper address bits alias; burst/protection info carries no meaning here
  logic                  unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HADDR[ADDR_WIDTH-1:IDX_W+2]};

  assign valid    = HSEL & HTRANS[1] & HREADY;
  assign bad_size = (HSIZE > 3'd2);
  assign idx      = HADDR[IDX_W+1:2];

  always_comb begin
    lane_mask = 4'b0000;
    case (HSIZE)
      3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
      3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  // The pending write has not reached the array yet at this edge, so merge
  // its lanes straight from HWDATA when a read hits the same word.
  always_comb begin
    rd_word = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_pend && (wr_idx == idx) && wr_mask[b]) begin
        rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= ST_OKAY;
      HREADY  <= 1'b1;
      HRESP   <= 1'b0;
      HRDATA  <= '0;
      wr_pend <= 1'b0;
      wr_idx  <= '0;
      wr_mask <= '0;
    end else begin
      wr_pend <= 1'b0;
      case (state)
        ST_ERR1: begin
          state  <= ST_ERR2;
          HREADY <= 1'b1;
          HRESP  <= 1'b1;
        end
        default: begin
          // The second ERROR cycle has HREADY high, so a new transfer may
          // start there just as in the OKAY state.
          if (valid && bad_size) begin
            state  <= ST_ERR1;
            HREADY <= 1'b0;
            HRESP  <= 1'b1;
          end else begin
            state  <= ST_OKAY;
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
            if (valid) begin
              if (HWRITE) begin
                wr_pend <= 1'b1;
                wr_idx  <= idx;
                wr_mask <= lane_mask;
              end else begin
                HRDATA  <= rd_word;
              end
            end
          end
        end
      endcase
    end
  end

  // Array has no reset; an asynchronous reset clears wr_pend, dropping the write
  always_ff @(posedge HCLK) begin
    if (wr_pend) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_join_none_slave.sv
// tb/tb_join_none_slave.sv - self-checking bench for join_none_slave
module tb_join_none_slave;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int tests = 0;
  int fails = 0;

  // Byte-addressed reference memory (4 KiB window, higher address bits alias)
  logic [7:0]  m_mem [4096];
  bit          m_pend;
  logic [15:0] m_paddr;
  logic [2:0]  m_psize;
  logic [31:0] m_pdata;
  int          m_err;     // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
  logic [31:0] exp_rdata;

  join_none_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] model_read(input logic [15:0] a);
    int base;
    base = {a[11:2], 2'b00};
    return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d);
    int base;
    int first;
    int count;
    base  = {a[11:2], 2'b00};
    count = 1 << sz;
    first = (a[1:0] / count) * count;
    for (int l = first; l < first + count; l++) m_mem[base+l] = d[8*l +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bus cycle: present an address phase (HWDATA carries the previous
  // write's data), advance the model at the edge, then check outputs.
  task automatic step(input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [2:0] sz, input logic [15:0] ad, input logic [31:0] dat);
    bit valid;
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = wr;
    HSIZE  = sz;
    HADDR  = ad;
    HBURST = 3'($urandom);
    HPROT  = 4'($urandom);
    HWDATA = m_pend ? m_pdata : $urandom;
    @(posedge HCLK);
    if (m_pend) model_write(m_paddr, m_psize, m_pdata);
    m_pend = 0;
    valid  = sel && tr[1] && (m_err != 1);
    if (m_err == 1)             m_err = 2;
    else if (valid && sz > 3'd2) m_err = 1;
    else                        m_err = 0;
    if (valid && sz <= 3'd2) begin
      if (wr) begin
        m_pend  = 1;
        m_paddr = ad;
        m_psize = sz;
        m_pdata = dat;
      end else begin
        exp_rdata = model_read(ad);
      end
    end
    #1;
    chk("hrdata", HRDATA, exp_rdata);
    chk("hready", {31'd0, HREADY}, {31'd0, m_err != 1});
    chk("hresp",  {31'd0, HRESP},  {31'd0, m_err != 0});
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 3'd2, 16'h0, 32'h0);
  endtask

  initial begin
    HRESET = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0;
    HBURST = 0; HPROT = 0; HWDATA = 0;
    m_pend = 0; m_err = 0; exp_rdata = 0;
    #1 HRESET = 1;
    #2;
    chk("reset_hrdata", HRDATA, 32'h0);
    chk("reset_hready", {31'd0, HREADY}, 32'd1);
    chk("reset_hresp",  {31'd0, HRESP},  32'd0);
    @(negedge HCLK) HRESET = 0;

    // Fill every word so the reference and the array agree everywhere
    for (int i = 0; i < 1024; i++) step(1'b1, 2'b10, 1'b1, 3'd2, 16'(i * 4), $urandom);
    idle();

    // Word write then read
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF);
    step(1'b1, 2'b10, 1'b0, 3'd2, 16'h0010, 32'h0);
    idle();
    chk("t1_word", HRDATA, 32'hDEADBEEF);

    // Byte write into lane 1
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF);
    step(1'b1, 2'b10, 1'b1, 3'd0, 16'h0011, 32'h0000AA00);
    idle();
    step(1'b1, 2'b10, 1'b0, 3'd2, 16'h0010, 32'h0);
    idle();
    chk("t2_byte", HRDATA, 32'hDEADAAEF);

    // Repeated write, idle, repeated read
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF);
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF);
    idle();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, 3'd2, 16'h0010, 32'h0);
    idle();
    idle();
    chk("t3_stable", HRDATA, 32'hDEADBEEF);

    // Read immediately after write (forwarding)
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0000, 32'h12345678);
    step(1'b1, 2'b10, 1'b0, 3'd2, 16'h0000, 32'h0);
    chk("t4_forward", HRDATA, 32'h12345678);
    idle();

    // Unsupported size: write presented in the first ERROR cycle is ignored
    step(1'b1, 2'b10, 1'b0, 3'd3, 16'h0010, 32'h0);
    chk("t5_err1_hready", {31'd0, HREADY}, 32'd0);
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0010, 32'h0);
    chk("t5_err2_hresp", {31'd0, HRESP}, 32'd1);
    idle();
    step(1'b1, 2'b10, 1'b0, 3'd2, 16'h0010, 32'h0);
    idle();
    chk("t5_unchanged", HRDATA, 32'hDEADBEEF);

    // Reset during a write data phase
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0040, 32'h11111111);
    idle();
    step(1'b1, 2'b10, 1'b1, 3'd2, 16'h0040, 32'hCAFEF00D);
    HSEL = 0; HTRANS = 2'b00; HWDATA = m_pdata;
    #2 HRESET = 1;
    #1;
    chk("t6_rst_hrdata", HRDATA, 32'h0);
    chk("t6_rst_hresp",  {31'd0, HRESP},  32'd0);
    chk("t6_rst_hready", {31'd0, HREADY}, 32'd1);
    m_pend = 0; m_err = 0; exp_rdata = 0;
    @(posedge HCLK);
    @(negedge HCLK) HRESET = 0;
    step(1'b1, 2'b10, 1'b0, 3'd2, 16'h0040, 32'h0);
    idle();
    chk("t6_not_written", HRDATA, 32'h11111111);

    // Randomised traffic with aliasing addresses and occasional bad sizes
    for (int i = 0; i < 400; i++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz,
           16'($urandom), $urandom);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
